fault_campaign_ctrl: RTL
========================

# fault_campaign_ctrl

Synthesizable sequencer for fault-injection campaigns on a small combinational netlist instantiated twice: a faulty copy and a golden copy, both driven from the same input vector. Each run draws a pseudo-random vector, applies it, and pulses a fault at one selected site of the faulty copy. The block then samples both copies on a clock edge, which models timing masking, and emits one result record per run over a valid/ready stream. It also keeps run and failure counters for the campaign.

## Interface
Parameters:
- N_IN, 5, input vector width driven to both netlist copies
- N_OUT, 2, output width of each copy
- N_SITES, 6, number of injectable fault sites; must be at least 1
- SITE_W, 3, width of the site index; ceil(log2(N_SITES)), minimum 1
- N_RUNS, 10000, number of runs per campaign (32-bit)
- SEED, 16'hACE1, LFSR seed; must be nonzero

Ports:
- clk, in, 1, system clock
- rst, in, 1, asynchronous active-high reset
- start, in, 1, campaign start; sampled only in IDLE or DONE
- busy, out, 1, high in APPLY, INJECT and REPORT
- done, out, 1, high in DONE
- vec, out, N_IN, input vector to both copies
- fault_en, out, 1, fault pulse to the faulty copy
- fault_site, out, SITE_W, site index for the fault pulse
- fl_out, in, N_OUT, faulty-copy outputs
- gd_out, in, N_OUT, golden-copy outputs
- res_valid, out, 1, result record valid
- res_ready, in, 1, sink accepts the record
- res_data, out, N_OUT+SITE_W+N_IN, record laid out as {mismatch, site, vec}
- run_cnt, out, 32, completed runs
- fail_cnt, out, 32, runs whose mismatch was nonzero

## Operation
- States are IDLE, APPLY, INJECT, REPORT and DONE.
- IDLE:
  - start=1 with N_RUNS>0 goes to APPLY.
  - start=1 with N_RUNS=0 goes directly to DONE.
  - On either start, run_cnt and fail_cnt clear, the site counter clears and the LFSR reloads SEED.
- APPLY (1 cycle):
  - vec is the registered copy of lfsr[N_IN-1:0].
  - fault_en=0.
  - Goes to INJECT.
- INJECT (1 cycle):
  - fault_en=1; fault_site holds the site counter.
  - On the edge leaving INJECT, the block registers mismatch = fl_out ^ gd_out together with site and vec into res_data.
  - Goes to REPORT.
- REPORT:
  - res_valid=1. res_data stays stable until the handshake res_valid & res_ready.
  - On the handshake, run_cnt increments, and fail_cnt increments if mismatch != 0.
  - The site counter advances and wraps from N_SITES-1 to 0.
  - The LFSR steps once.
  - Goes to APPLY, or to DONE if the new run_cnt equals N_RUNS.
- DONE:
  - done=1. Counters hold.
  - start=1 restarts the campaign exactly as from IDLE.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts left, new bit goes in at bit 0.
- start is ignored while busy.
- Counters wrap modulo 2^32; they never saturate.

## Timing
- Reset values (async, rst=1):
  - State IDLE.
  - vec=0, fault_en=0, fault_site=0.
  - res_valid=0, res_data=0.
  - run_cnt=0, fail_cnt=0.
  - busy=0, done=0.
  - LFSR=SEED.
- All outputs are registered; none depends combinationally on inputs.
- Per-run latency with res_ready held high is 3 cycles: APPLY, INJECT, REPORT.
- The first res_valid appears 3 cycles after the edge that samples start.
- fault_en is high for exactly one cycle per run and is never high outside INJECT.
- Backpressure: REPORT holds indefinitely while res_ready=0. vec and fault_site stay stable during the hold; fault_en stays 0.
- rst asserted mid-run aborts immediately to the reset values. No partial record is emitted.

## Structure
- Shared package fault_campaign_pkg holds:
  - the state enum
  - the LFSR tap constant and width (16)
  - a helper function for the result-record width
- One sub-module, lfsr16, with ports clk, rst, load, seed, step and q.
- The counters and FSM stay in the top module.

## Test plan
- N_RUNS=1, fl_out tied to gd_out, res_ready=1 → exactly one record with mismatch=0, site=0 and vec=SEED[4:0]; run_cnt=1, fail_cnt=0; done rises 4 cycles after start.
- N_RUNS=8, N_SITES=6, fl_out forced to gd_out^2'b01 during INJECT → 8 records with sites 0,1,2,3,4,5,0,1 and mismatch=2'b01 each; fail_cnt=8.
- res_ready held low 5 cycles in the first REPORT → res_data stable and fault_en=0 throughout; run_cnt steps only on the handshake.
- N_RUNS=0 with start pulsed → DONE on the next cycle; res_valid never asserted; run_cnt=0.
- rst pulsed during INJECT of run 3 → all outputs return to reset values at once. A subsequent start replays the identical vec sequence from SEED.
- start pulsed while busy → ignored: counters are unaffected and the campaign completes normally.

Source files
------------

// File: rtl/fault_campaign_pkg.sv
// Shared types and constants for the fault-injection campaign sequencer.
package fault_campaign_pkg;

    localparam int unsigned LFSR_W    = 16;
    // x^16 + x^14 + x^13 + x^11 + 1 expressed as a mask over q[15:0]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_INJECT = 3'd2,
        ST_REPORT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic int unsigned rec_width(
        input int unsigned n_out,
        input int unsigned site_w,
        input int unsigned n_in
    );
        return n_out + site_w + n_in;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left with the feedback bit entering at bit 0.
module lfsr16
    import fault_campaign_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    logic feedback_c;

    assign feedback_c = ^(q & LFSR_TAPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= seed;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= {q[LFSR_W-2:0], feedback_c};
        end
    end

endmodule

// File: rtl/fault_campaign_ctrl.sv
// Fault-injection campaign sequencer: drives a vector and one fault pulse per run,
// captures the faulty/golden difference and streams one record per run.
module fault_campaign_ctrl
    import fault_campaign_pkg::*;
#(
    parameter int unsigned       N_IN    = 5,
    parameter int unsigned       N_OUT   = 2,
    parameter int unsigned       N_SITES = 6,
    parameter int unsigned       SITE_W  = 3,
    parameter int unsigned       N_RUNS  = 10000,
    parameter logic [LFSR_W-1:0] SEED    = 16'hACE1
)
(
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    output logic                                          busy,
    output logic                                          done,
    output logic [N_IN-1:0]                               vec,
    output logic                                          fault_en,
    output logic [SITE_W-1:0]                             fault_site,
    input  logic [N_OUT-1:0]                              fl_out,
    input  logic [N_OUT-1:0]                              gd_out,
    output logic                                          res_valid,
    input  logic                                          res_ready,
    output logic [rec_width(N_OUT, SITE_W, N_IN)-1:0]     res_data,
    output logic [31:0]                                   run_cnt,
    output logic [31:0]                                   fail_cnt
);

    localparam int unsigned REC_W = rec_width(N_OUT, SITE_W, N_IN);

    state_t            state;
    state_t            state_nxt;
    logic              lfsr_load;
    logic              lfsr_step;
    logic              clr_cnt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              fault_en_nxt;
    logic              res_valid_nxt;
    logic              handshake;
    logic              last_run;
    logic              rec_fail;
    logic [LFSR_W-1:0] lfsr_q;
    logic              lfsr_unused;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (SEED),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    // Only the low N_IN bits feed the vector; the rest are internal LFSR state.
    assign lfsr_unused = ^lfsr_q;

    assign handshake = res_valid & res_ready;
    assign last_run  = (run_cnt + 32'd1) == 32'(N_RUNS);
    assign rec_fail  = |res_data[REC_W-1 -: N_OUT];

    // Next-state and next-output decode.
    always_comb begin
        state_nxt = state;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        clr_cnt   = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clr_cnt   = 1'b1;
                    lfsr_load = 1'b1;
                    state_nxt = (32'(N_RUNS) == 32'd0) ? ST_DONE : ST_APPLY;
                end
            end
            ST_APPLY:  state_nxt = ST_INJECT;
            ST_INJECT: state_nxt = ST_REPORT;
            ST_REPORT: begin
                if (handshake) begin
                    lfsr_step = 1'b1;
                    state_nxt = last_run ? ST_DONE : ST_APPLY;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase

        busy_nxt      = (state_nxt == ST_APPLY) || (state_nxt == ST_INJECT) ||
                        (state_nxt == ST_REPORT);
        done_nxt      = (state_nxt == ST_DONE);
        fault_en_nxt  = (state_nxt == ST_INJECT);
        res_valid_nxt = (state_nxt == ST_REPORT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault_en  <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            fault_en  <= fault_en_nxt;
            res_valid <= res_valid_nxt;
        end
    end

    // The site counter doubles as the fault_site output so it is stable through REPORT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt    <= '0;
            fail_cnt   <= '0;
            fault_site <= '0;
        end else if (clr_cnt) begin
            run_cnt    <= '0;
            fail_cnt   <= '0;
            fault_site <= '0;
        end else if (handshake) begin
            run_cnt <= run_cnt + 32'd1;
            if (rec_fail) begin
                fail_cnt <= fail_cnt + 32'd1;
            end
            if (fault_site == SITE_W'(N_SITES - 1)) begin
                fault_site <= '0;
            end else begin
                fault_site <= fault_site + SITE_W'(1);
            end
        end
    end

    // Vector is latched leaving APPLY; the record is latched on the edge leaving INJECT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec      <= '0;
            res_data <= '0;
        end else begin
            if (state == ST_APPLY) begin
                vec <= lfsr_q[N_IN-1:0];
            end
            if (state == ST_INJECT) begin
                res_data <= {fl_out ^ gd_out, fault_site, vec};
            end
        end
    end

endmodule
